inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/inst_fetch.sv | 154 +++++++++++++++
 tb/tb_inst_fetch.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared CPU constants and instruction fetch state codes
package inst_fetch_pkg;

    localparam logic [31:0] ZeroWord         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_REQ  = 3'd0;
    localparam fetch_state_t ST_WAIT = 3'd1;
    localparam fetch_state_t ST_HOLD = 3'd2;
    localparam fetch_state_t ST_EXC  = 3'd3;
    localparam fetch_state_t ST_IDLE = 3'd4;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    // Every path into REQ goes through here so a bad PC never reaches the bus.
    function automatic fetch_state_t entry_state(input logic [31:0] pc);
        return pc_misaligned(pc) ? ST_EXC : ST_REQ;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch stage feeding the IF/ID register
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        addr_exception_o
);

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic [31:0]  restart_pc, restart_pc_nxt;
    logic [31:0]  redir_pc, redir_pc_nxt;
    logic [31:0]  inst_buf, inst_buf_nxt;
    logic         cancel, cancel_nxt;
    logic         redir_valid, redir_valid_nxt;

    logic [31:0]  seq_pc;
    logic [31:0]  consume_pc;
    logic [31:0]  wait_restart_pc;

    assign seq_pc = fetch_pc + 32'd4;

    // A branch resolving on the same edge that its delay slot leaves IF must
    // steer the very next fetch, so it beats any older pending redirect.
    assign consume_pc = branch_i    ? branch_target_i :
                        redir_valid ? redir_pc        : seq_pc;

    // A flush landing together with the returning data still drops that data.
    assign wait_restart_pc = flush_i ? flush_pc_i : restart_pc;

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        restart_pc_nxt  = restart_pc;
        redir_pc_nxt    = redir_pc;
        inst_buf_nxt    = inst_buf;
        cancel_nxt      = cancel;
        redir_valid_nxt = redir_valid;

        if (branch_i && !stall_i) begin
            redir_valid_nxt = 1'b1;
            redir_pc_nxt    = branch_target_i;
        end

        case (state)
            ST_REQ: begin
                if (flush_i) begin
                    cancel_nxt      = 1'b1;
                    restart_pc_nxt  = flush_pc_i;
                    redir_valid_nxt = 1'b0;
                end
                if (inst_addr_ok_i) begin
                    state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (flush_i) begin
                    cancel_nxt      = 1'b1;
                    restart_pc_nxt  = flush_pc_i;
                    redir_valid_nxt = 1'b0;
                end
                if (inst_data_ok_i) begin
                    if (flush_i || cancel) begin
                        cancel_nxt   = 1'b0;
                        fetch_pc_nxt = wait_restart_pc;
                        state_nxt    = entry_state(wait_restart_pc);
                    end else begin
                        inst_buf_nxt = inst_rdata_i;
                        state_nxt    = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (flush_i) begin
                    fetch_pc_nxt    = flush_pc_i;
                    redir_valid_nxt = 1'b0;
                    state_nxt       = entry_state(flush_pc_i);
                end else if (!stall_i) begin
                    fetch_pc_nxt    = consume_pc;
                    redir_valid_nxt = 1'b0;
                    state_nxt       = entry_state(consume_pc);
                end
            end

            ST_EXC: begin
                if (flush_i) begin
                    fetch_pc_nxt    = flush_pc_i;
                    redir_valid_nxt = 1'b0;
                    state_nxt       = entry_state(flush_pc_i);
                end else if (!stall_i) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (flush_i) begin
                    fetch_pc_nxt    = flush_pc_i;
                    redir_valid_nxt = 1'b0;
                    state_nxt       = entry_state(flush_pc_i);
                end
            end

            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_REQ;
            fetch_pc    <= RESET_PC;
            restart_pc  <= ZeroWord;
            redir_pc    <= ZeroWord;
            inst_buf    <= ZeroWord;
            cancel      <= 1'b0;
            redir_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            restart_pc  <= restart_pc_nxt;
            redir_pc    <= redir_pc_nxt;
            inst_buf    <= inst_buf_nxt;
            cancel      <= cancel_nxt;
            redir_valid <= redir_valid_nxt;
        end
    end

    // Reset parks the FSM in REQ, so the request is gated off until release.
    assign inst_req_o       = (state == ST_REQ) && !rst_i;
    assign inst_addr_o      = fetch_pc;

    assign if_pc_o          = (state == ST_HOLD || state == ST_EXC) ? fetch_pc : ZeroWord;
    assign if_inst_o        = (state == ST_HOLD) ? inst_buf : ZeroWord;
    assign addr_exception_o = (state == ST_EXC);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk_i           = 1'b0;
    logic        rst_i           = 1'b0;
    logic        stall_i         = 1'b0;
    logic        flush_i         = 1'b0;
    logic [31:0] flush_pc_i      = 32'h0;
    logic        branch_i        = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        inst_addr_ok_i  = 1'b0;
    logic        inst_data_ok_i  = 1'b0;
    logic [31:0] inst_rdata_i    = 32'h0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        addr_exception_o;

    int vectors     = 0;
    int miscompares = 0;
    int data_lat    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } item_t;

    logic [31:0] exp_req_q[$];
    item_t       exp_dl_q[$];

    inst_fetch dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i),
        .branch_i         (branch_i),
        .branch_target_i  (branch_target_i),
        .inst_req_o       (inst_req_o),
        .inst_addr_o      (inst_addr_o),
        .inst_addr_ok_i   (inst_addr_ok_i),
        .inst_data_ok_i   (inst_data_ok_i),
        .inst_rdata_i     (inst_rdata_i),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .addr_exception_o (addr_exception_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: 0xBFC0_0000 holds 0x2400_0001.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h6440_0001;
    endfunction

    function automatic bit presented();
        return (if_pc_o != 32'h0) || (if_inst_o != 32'h0) || addr_exception_o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_hold(input logic [31:0] pc);
        item_t it;
        it.pc = pc; it.inst = mem(pc); it.exc = 1'b0;
        exp_dl_q.push_back(it);
    endtask

    task automatic push_exc(input logic [31:0] pc);
        item_t it;
        it.pc = pc; it.inst = 32'h0; it.exc = 1'b1;
        exp_dl_q.push_back(it);
    endtask

    task automatic wait_present(input logic [31:0] pc);
        int n = 0;
        while (!(presented() && if_pc_o == pc) && n < 60) begin
            cyc();
            n++;
        end
        chk("wait_present_reached", {31'b0, n < 60}, 32'd1);
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (!(inst_req_o && inst_addr_o == addr) && n < 60) begin
            cyc();
            n++;
        end
        chk("wait_req_reached", {31'b0, n < 60}, 32'd1);
    endtask

    task automatic drain_check();
        chk("req_queue_empty", exp_req_q.size(), 32'd0);
        chk("deliv_queue_empty", exp_dl_q.size(), 32'd0);
    endtask

    // Memory slave: grants every request at once, returns data data_lat cycles later.
    initial begin : responder
        logic [31:0] pend_addr;
        bit          pend;
        int          dcnt;
        pend = 0; dcnt = 0; pend_addr = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            if (inst_addr_ok_i) begin
                pend = 1;
                dcnt = 0;
            end
            if (inst_data_ok_i) pend = 0;
            inst_addr_ok_i = 1'b0;
            inst_data_ok_i = 1'b0;
            if (rst_i) begin
                pend = 0;
            end else if (pend) begin
                if (dcnt >= data_lat) begin
                    inst_data_ok_i = 1'b1;
                    inst_rdata_i   = mem(pend_addr);
                end else begin
                    dcnt++;
                end
            end else if (inst_req_o) begin
                inst_addr_ok_i = 1'b1;
                pend_addr      = inst_addr_o;
            end
        end
    end

    // Reference checks every cycle: request order, delivered stream, bus and stall rules.
    initial begin : compare
        bit          prev_valid, prev_req, prev_ok, prev_pres, prev_stall, prev_flush, pres, prev_exc;
        logic [31:0] prev_addr, prev_pc, prev_inst;
        item_t       it;
        prev_valid = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_valid = 0;
                continue;
            end
            pres = presented();
            if (pres) chk("no_req_while_presenting", {31'b0, inst_req_o}, 32'd0);
            if (prev_valid && prev_req && !prev_ok) begin
                chk("req_held", {31'b0, inst_req_o}, 32'd1);
                chk("req_addr_stable", inst_addr_o, prev_addr);
            end
            if (prev_valid && prev_pres && prev_stall && !prev_flush) begin
                chk("stall_pc_held", if_pc_o, prev_pc);
                chk("stall_inst_held", if_inst_o, prev_inst);
                chk("stall_exc_held", {31'b0, addr_exception_o}, {31'b0, prev_exc});
            end
            if (inst_req_o && inst_addr_ok_i) begin
                if (exp_req_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_req: got addr %h expected no request", inst_addr_o);
                end else begin
                    chk("req_addr", inst_addr_o, exp_req_q.pop_front());
                end
            end
            if (pres && !stall_i && !flush_i) begin
                if (exp_dl_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_delivery: got pc %h expected nothing", if_pc_o);
                end else begin
                    it = exp_dl_q.pop_front();
                    chk("deliv_pc", if_pc_o, it.pc);
                    chk("deliv_inst", if_inst_o, it.inst);
                    chk("deliv_exc", {31'b0, addr_exception_o}, {31'b0, it.exc});
                end
            end
            prev_valid = 1;
            prev_req   = inst_req_o;
            prev_ok    = inst_addr_ok_i;
            prev_addr  = inst_addr_o;
            prev_pres  = pres;
            prev_stall = stall_i;
            prev_flush = flush_i;
            prev_pc    = if_pc_o;
            prev_inst  = if_inst_o;
            prev_exc   = addr_exception_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int          n;
        logic [31:0] hold_pc, hold_inst;

        // Reset, first fetch, latency
        #1 rst_i = 1'b1;
        cyc(); cyc();
        chk("rst_req", {31'b0, inst_req_o}, 32'd0);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_if_inst", if_inst_o, 32'h0);
        chk("rst_exc", {31'b0, addr_exception_o}, 32'd0);
        exp_req_q.push_back(32'hBFC0_0000);
        exp_req_q.push_back(32'hBFC0_0004);
        push_hold(32'hBFC0_0000);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("first_req", {31'b0, inst_req_o}, 32'd1);
        chk("first_addr", inst_addr_o, 32'hBFC0_0000);
        cyc();
        n = 0;
        while (!presented() && n < 10) begin
            cyc();
            n++;
        end
        stall_i = 1'b1;
        chk("hold_latency", n, 32'd2);
        chk("first_pc", if_pc_o, 32'hBFC0_0000);
        chk("first_inst", if_inst_o, 32'h2400_0001);
        chk("first_exc", {31'b0, addr_exception_o}, 32'd0);

        // Stall three cycles in HOLD
        hold_pc = if_pc_o;
        hold_inst = if_inst_o;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", if_pc_o, hold_pc);
            chk("stall_inst", if_inst_o, hold_inst);
            chk("stall_no_req", {31'b0, inst_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        cyc();
        chk("next_req", {31'b0, inst_req_o}, 32'd1);
        chk("next_addr", inst_addr_o, 32'hBFC0_0004);

        // Branch while the delay slot is being fetched
        push_hold(32'hBFC0_0004);
        push_hold(32'hBFC0_0008);
        exp_req_q.push_back(32'hBFC0_0008);
        exp_req_q.push_back(32'hBFC0_0100);
        wait_req(32'hBFC0_0008);
        branch_i = 1'b1;
        branch_target_i = 32'hBFC0_0100;
        cyc();
        branch_i = 1'b0;
        wait_present(32'hBFC0_0100);
        stall_i = 1'b1;
        chk("branch_target_inst", if_inst_o, mem(32'hBFC0_0100));
        drain_check();

        // Flush while waiting for data, then a second flush overwrites the restart PC
        data_lat = 3;
        push_hold(32'hBFC0_0100);
        exp_req_q.push_back(32'hBFC0_0104);
        exp_req_q.push_back(32'hBFC0_0380);
        stall_i = 1'b0;
        cyc();
        cyc();
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0200;
        cyc();
        flush_pc_i = 32'hBFC0_0380;
        cyc();
        flush_i = 1'b0;
        wait_present(32'hBFC0_0380);
        stall_i = 1'b1;
        drain_check();

        // Flush on the same cycle the data returns
        data_lat = 0;
        push_hold(32'hBFC0_0380);
        exp_req_q.push_back(32'hBFC0_0384);
        exp_req_q.push_back(32'hBFC0_0500);
        stall_i = 1'b0;
        cyc();
        cyc();
        chk("data_ok_in_wait", {31'b0, inst_data_ok_i}, 32'd1);
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0500;
        cyc();
        flush_i = 1'b0;
        wait_present(32'hBFC0_0500);
        stall_i = 1'b1;
        drain_check();

        // Branch to a misaligned target: exception, idle, flush resumes
        push_hold(32'hBFC0_0500);
        push_hold(32'hBFC0_0504);
        push_exc(32'hBFC0_0102);
        exp_req_q.push_back(32'hBFC0_0504);
        stall_i = 1'b0;
        wait_req(32'hBFC0_0504);
        branch_i = 1'b1;
        branch_target_i = 32'hBFC0_0102;
        cyc();
        branch_i = 1'b0;
        wait_present(32'hBFC0_0102);
        chk("exc_pc", if_pc_o, 32'hBFC0_0102);
        chk("exc_flag", {31'b0, addr_exception_o}, 32'd1);
        chk("exc_inst", if_inst_o, 32'h0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("idle_no_req", {31'b0, inst_req_o}, 32'd0);
            chk("idle_pc", if_pc_o, 32'h0);
            chk("idle_exc", {31'b0, addr_exception_o}, 32'd0);
            cyc();
        end
        exp_req_q.push_back(32'hBFC0_0380);
        flush_i = 1'b1;
        flush_pc_i = 32'hBFC0_0380;
        cyc();
        flush_i = 1'b0;
        chk("resume_req", {31'b0, inst_req_o}, 32'd1);
        chk("resume_addr", inst_addr_o, 32'hBFC0_0380);
        wait_present(32'hBFC0_0380);
        stall_i = 1'b1;
        drain_check();

        // Flush under stall to the top word, then wrap to zero
        exp_req_q.push_back(32'hFFFF_FFFC);
        exp_req_q.push_back(32'h0000_0000);
        push_hold(32'hFFFF_FFFC);
        flush_i = 1'b1;
        flush_pc_i = 32'hFFFF_FFFC;
        cyc();
        flush_i = 1'b0;
        stall_i = 1'b0;
        chk("top_addr", inst_addr_o, 32'hFFFF_FFFC);
        wait_req(32'h0000_0000);
        chk("wrap_addr", inst_addr_o, 32'h0000_0000);
        wait_present(32'h0000_0000);
        stall_i = 1'b1;
        chk("wrap_inst", if_inst_o, 32'h6440_0001);
        drain_check();

        // Reset in the middle of a transaction
        data_lat = 3;
        push_hold(32'h0000_0000);
        exp_req_q.push_back(32'h0000_0004);
        stall_i = 1'b0;
        cyc();
        cyc();
        rst_i = 1'b1;
        #1;
        chk("midrst_req", {31'b0, inst_req_o}, 32'd0);
        chk("midrst_pc", if_pc_o, 32'h0);
        cyc(); cyc();
        data_lat = 0;
        exp_req_q.push_back(32'hBFC0_0000);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("rerst_addr", inst_addr_o, 32'hBFC0_0000);
        wait_present(32'hBFC0_0000);
        stall_i = 1'b1;
        chk("rerst_inst", if_inst_o, 32'h2400_0001);
        cyc();
        drain_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
